vid_timing_rx: RTL and testbench

//  Receive end of the DE/HS/VS/RGB video interface driven by the pattern generator.

---
 rtl/vid_timing_rx.sv | 124 ++++++++++++
 tb/tb_vid_timing_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vid_timing_rx.sv
// vid_timing_rx: video timing receiver, measures line/frame timing, locks on stable timing, re-emits active pixels
module vid_timing_rx #(
  parameter int CNT_W       = 12,
  parameter bit HS_ACT      = 1'b1,
  parameter bit VS_ACT      = 1'b1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             vgaclk,
  input  logic             reset_n,
  input  logic             vid_de,
  input  logic             vid_hs,
  input  logic             vid_vs,
  input  logic [7:0]       vid_r,
  input  logic [7:0]       vid_g,
  input  logic [7:0]       vid_b,
  output logic [23:0]      o_rgb,
  output logic             o_valid,
  output logic             o_sof,
  output logic             o_eol,
  output logic             locked,
  output logic             unlock_err,
  output logic [CNT_W-1:0] meas_h_total,
  output logic [CNT_W-1:0] meas_h_active,
  output logic [CNT_W-1:0] meas_v_total,
  output logic [CNT_W-1:0] meas_v_active
);
  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;
  localparam int F_W = 4 * CNT_W;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == '1) ? x : x + 1'b1;
  endfunction

  logic de1, hs1, vs1, hs_p, vs_p, de2, sof2, arm;
  logic [23:0] rgb1, rgb2;
  logic [CNT_W-1:0] h_cnt, cur_h_total, de_cnt, first_len, v_cnt, v_act_cnt, f_h, f_v;
  logic first_seen, frame_bad;
  logic [F_W-1:0] frame, prev_f;
  logic [3:0] match_cnt;
  state_t state;
  logic hs_rise, vs_rise, de_fall, match, timeout;

  assign hs_rise = hs1 & ~hs_p;
  assign vs_rise = vs1 & ~vs_p;
  assign de_fall = de2 & ~de1;
  // an HS edge coinciding with VS still belongs to the ending frame
  assign f_h     = hs_rise ? sat_inc(h_cnt) : cur_h_total;
  assign f_v     = hs_rise ? sat_inc(v_cnt) : v_cnt;
  assign frame   = {f_h, first_len, f_v, v_act_cnt};
  assign match   = (frame == prev_f) && !frame_bad;
  assign timeout = (v_cnt == '1);

  always_ff @(posedge vgaclk)
    if (!reset_n) begin
      {de1, hs1, vs1, hs_p, vs_p, de2, sof2, arm, rgb1, rgb2} <= '0;
      {o_rgb, o_valid, o_sof, o_eol} <= '0;
    end else begin
      de1     <= vid_de;
      hs1     <= vid_hs == HS_ACT;
      vs1     <= vid_vs == VS_ACT;
      rgb1    <= {vid_r, vid_g, vid_b};
      hs_p    <= hs1;
      vs_p    <= vs1;
      de2     <= de1;
      rgb2    <= rgb1;
      sof2    <= de1 & arm;
      arm     <= vs_rise | (arm & ~de1);
      o_rgb   <= rgb2;
      o_valid <= de2;
      o_eol   <= de_fall;
      o_sof   <= sof2;
    end

  always_ff @(posedge vgaclk)
    if (!reset_n) begin
      {h_cnt, cur_h_total, de_cnt, first_len, v_cnt, v_act_cnt} <= '0;
      {first_seen, frame_bad} <= '0;
    end else begin
      h_cnt  <= hs_rise ? '0 : sat_inc(h_cnt);
      de_cnt <= de1 ? sat_inc(de_cnt) : '0;
      if (hs_rise) cur_h_total <= sat_inc(h_cnt);
      v_cnt <= vs_rise ? '0 : hs_rise ? sat_inc(v_cnt) : v_cnt;
      if (vs_rise) begin
        v_act_cnt  <= '0;
        frame_bad  <= 1'b0;
        first_seen <= 1'b0;
      end else if (de_fall) begin
        v_act_cnt  <= sat_inc(v_act_cnt);
        first_seen <= 1'b1;
        if (first_seen) frame_bad <= frame_bad | (de_cnt != first_len);
        else first_len <= de_cnt;
      end
    end

  always_ff @(posedge vgaclk)
    if (!reset_n) begin
      state      <= SEARCH;
      match_cnt  <= '0;
      prev_f     <= '0;
      locked     <= 1'b0;
      unlock_err <= 1'b0;
      {meas_h_total, meas_h_active, meas_v_total, meas_v_active} <= '0;
    end else begin
      unlock_err <= 1'b0;
      if (vs_rise) begin
        prev_f <= frame;
        if (state == SEARCH || !match) begin
          state      <= CHECK;
          match_cnt  <= '0;
          locked     <= 1'b0;
          unlock_err <= state == LOCKED;
        end else if (state == LOCKED || 5'(match_cnt) + 5'd2 >= 5'(LOCK_FRAMES)) begin
          state  <= LOCKED;
          locked <= 1'b1;
          {meas_h_total, meas_h_active, meas_v_total, meas_v_active} <= frame;
        end else
          match_cnt <= match_cnt + 1'b1;
      end else if (timeout && state != SEARCH) begin
        state      <= SEARCH;
        locked     <= 1'b0;
        unlock_err <= state == LOCKED;
      end
    end
endmodule

// File: tb/tb_vid_timing_rx.sv
// tb_vid_timing_rx: directed tests on a scaled-down raster (20x10 total, 12x6 active, CNT_W=8)
module tb_vid_timing_rx;
  localparam int W = 8, H_TOT = 20, H_ACT = 12, V_TOT = 10, V_ACT = 6;

  logic vgaclk = 0, reset_n = 0, vid_de = 0, vid_hs = 0, vid_vs = 0;
  logic [7:0] vid_r = 0, vid_g = 0, vid_b = 0;
  logic [23:0] o_rgb;
  logic o_valid, o_sof, o_eol, locked, unlock_err;
  logic [W-1:0] meas_h_total, meas_h_active, meas_v_total, meas_v_active;
  logic [60:0] all_o;
  logic [31:0] meas;

  int tests = 0, fails = 0;
  int unlock_cnt = 0, eol_cnt = 0, eol_bad = 0, sof_cnt = 0, pipe_err = 0;
  logic [23:0] sof_rgb = '1;
  bit chk_pipe = 0;
  logic [24:0] hist [3] = '{default: '0};

  vid_timing_rx #(.CNT_W(W)) dut (
    .vgaclk(vgaclk), .reset_n(reset_n), .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs),
    .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b), .o_rgb(o_rgb), .o_valid(o_valid),
    .o_sof(o_sof), .o_eol(o_eol), .locked(locked), .unlock_err(unlock_err),
    .meas_h_total(meas_h_total), .meas_h_active(meas_h_active),
    .meas_v_total(meas_v_total), .meas_v_active(meas_v_active)
  );

  assign all_o = {o_rgb, o_valid, o_sof, o_eol, locked, unlock_err,
                  meas_h_total, meas_h_active, meas_v_total, meas_v_active};
  assign meas  = {meas_h_total, meas_h_active, meas_v_total, meas_v_active};

  always #5 vgaclk = ~vgaclk;

  // inputs change 1ns after posedge; outputs are observed at negedge against a 3-deep input history
  always @(negedge vgaclk) begin
    if (chk_pipe && {o_valid, o_rgb} !== hist[2]) pipe_err++;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = {vid_de, vid_r, vid_g, vid_b};
    if (unlock_err) unlock_cnt++;
    if (o_valid && o_eol) begin
      eol_cnt++;
      if (o_rgb !== 24'd11) eol_bad++;
    end
    if (o_valid && o_sof) begin
      sof_cnt++;
      sof_rgb = o_rgb;
    end
  end

  task automatic drive_pix(input int line, input int c, input int bad_line, input bit vs_en);
    @(posedge vgaclk); #1;
    vid_de = (line < V_ACT) && (c < ((line == bad_line) ? H_ACT - 2 : H_ACT));
    vid_hs = (c >= H_ACT + 2) && (c < H_ACT + 4);
    vid_vs = vs_en && ((line == V_ACT + 1 && c >= H_ACT + 2) || line == V_ACT + 2 ||
                       (line == V_ACT + 3 && c < H_ACT + 2));
    {vid_r, vid_g, vid_b} = 24'(c);
  endtask

  task automatic run_frame(input int htot, input int bad_line, input bit vs_en);
    for (int l = 0; l < V_TOT; l++)
      for (int c = 0; c < htot; c++) drive_pix(l, c, bad_line, vs_en);
  endtask

  task automatic do_reset;
    @(posedge vgaclk); #1;
    reset_n = 0;
    {vid_de, vid_hs, vid_vs, vid_r, vid_g, vid_b} = '0;
    @(posedge vgaclk); #1;
    reset_n = 1;
  endtask

  task automatic test_reset;
    vid_de = 1; vid_hs = 1; vid_vs = 1; {vid_r, vid_g, vid_b} = 24'hABCDEF;
    do_reset();
    tests++;
    if (all_o !== '0) begin fails++; $display("FAIL reset_state: got %h want 0", all_o); end
  endtask

  task automatic test_lock;
    bit exp_l [4] = '{0, 0, 1, 1};
    unlock_cnt = 0;
    for (int f = 0; f < 4; f++) begin
      run_frame(H_TOT, -1, 1);
      tests++;
      if (locked !== exp_l[f]) begin
        fails++; $display("FAIL lock_frame%0d: got %b want %b", f, locked, exp_l[f]);
      end
    end
    tests++;
    if (meas !== {8'd20, 8'd12, 8'd10, 8'd6}) begin
      fails++; $display("FAIL lock_meas: got %h want 140c0a06", meas);
    end
    tests++;
    if (unlock_cnt != 0) begin fails++; $display("FAIL lock_unlock_err: got %0d want 0", unlock_cnt); end
  endtask

  task automatic test_pixel;
    eol_cnt = 0; eol_bad = 0; sof_cnt = 0; pipe_err = 0; sof_rgb = '1; chk_pipe = 1;
    for (int l = 0; l < V_TOT; l++)
      for (int c = 0; c < H_TOT; c++) begin
        drive_pix(l, c, -1, 1);
        if (l == 0 && c == 2) begin
          tests++;
          if (o_valid !== 1'b0) begin fails++; $display("FAIL pix_early_valid: got %b want 0", o_valid); end
        end
        if (l == 0 && c == 3) begin
          tests++;
          if ({o_valid, o_sof, o_rgb} !== {2'b11, 24'd0}) begin
            fails++; $display("FAIL pix_first: got v=%b s=%b rgb=%h want v=1 s=1 rgb=0", o_valid, o_sof, o_rgb);
          end
        end
      end
    chk_pipe = 0;
    tests++;
    if (pipe_err != 0) begin fails++; $display("FAIL pix_delay3: got %0d errors want 0", pipe_err); end
    tests++;
    if (eol_cnt != 6) begin fails++; $display("FAIL pix_eol_count: got %0d want 6", eol_cnt); end
    tests++;
    if (eol_bad != 0) begin fails++; $display("FAIL pix_eol_pixel: got %0d wrong want 0", eol_bad); end
    tests++;
    if (sof_cnt != 1) begin fails++; $display("FAIL pix_sof_count: got %0d want 1", sof_cnt); end
    tests++;
    if (sof_rgb !== 24'd0) begin fails++; $display("FAIL pix_sof_rgb: got %h want 0", sof_rgb); end
  endtask

  task automatic test_unlock;
    unlock_cnt = 0;
    run_frame(H_TOT - 1, -1, 1);
    tests++;
    if (locked !== 1'b0) begin fails++; $display("FAIL unlock_drop: got %b want 0", locked); end
    tests++;
    if (meas !== {8'd20, 8'd12, 8'd10, 8'd6}) begin
      fails++; $display("FAIL unlock_meas_hold: got %h want 140c0a06", meas);
    end
    run_frame(H_TOT, -1, 1);
    tests++;
    if (locked !== 1'b0) begin fails++; $display("FAIL unlock_relock_early: got %b want 0", locked); end
    run_frame(H_TOT, -1, 1);
    tests++;
    if (locked !== 1'b1) begin fails++; $display("FAIL unlock_relock: got %b want 1", locked); end
    tests++;
    if (unlock_cnt != 1) begin fails++; $display("FAIL unlock_pulses: got %0d want 1", unlock_cnt); end
  endtask

  task automatic test_timeout;
    unlock_cnt = 0;
    for (int f = 0; f < 20; f++) run_frame(H_TOT, -1, 0);
    tests++;
    if (locked !== 1'b1) begin fails++; $display("FAIL timeout_early: got %b want 1", locked); end
    for (int f = 0; f < 6; f++) run_frame(H_TOT, -1, 0);
    tests++;
    if (locked !== 1'b0) begin fails++; $display("FAIL timeout_locked: got %b want 0", locked); end
    tests++;
    if (unlock_cnt != 1) begin fails++; $display("FAIL timeout_pulses: got %0d want 1", unlock_cnt); end
  endtask

  task automatic test_bad_line;
    do_reset();
    run_frame(H_TOT, -1, 1);
    run_frame(H_TOT, -1, 1);
    run_frame(H_TOT, 2, 1);
    tests++;
    if (locked !== 1'b0) begin fails++; $display("FAIL bad_line_nolock: got %b want 0", locked); end
    run_frame(H_TOT, -1, 1);
    tests++;
    if (locked !== 1'b1) begin fails++; $display("FAIL bad_line_lock_after: got %b want 1", locked); end
  endtask

  task automatic test_reset_mid;
    tests++;
    if (locked !== 1'b1) begin fails++; $display("FAIL rstmid_pre: got %b want 1", locked); end
    for (int l = 0; l < V_TOT; l++)
      for (int c = 0; c < H_TOT; c++) begin
        drive_pix(l, c, -1, 1);
        if (l == 3 && c == 5) reset_n = 0;
        if (l == 3 && c == 6) begin
          reset_n = 1;
          tests++;
          if (all_o !== '0) begin fails++; $display("FAIL rstmid_zero: got %h want 0", all_o); end
        end
      end
    tests++;
    if (locked !== 1'b0) begin fails++; $display("FAIL rstmid_vs1: got %b want 0", locked); end
    run_frame(H_TOT, -1, 1);
    tests++;
    if (locked !== 1'b0) begin fails++; $display("FAIL rstmid_vs2: got %b want 0", locked); end
    run_frame(H_TOT, -1, 1);
    tests++;
    if (locked !== 1'b1) begin fails++; $display("FAIL rstmid_vs3: got %b want 1", locked); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_pixel();
    test_unlock();
    test_timeout();
    test_bad_line();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
